puf_challenge_sequencer: RTL and testbench
==========================================

# puf_challenge_sequencer

Initiator side of the ring-oscillator PUF. Issues a sequence of 5-bit challenges to the oscillator select mux pair and gates the oscillator enable. Counts the two selected oscillator outputs over a fixed clk-referenced window and compares the counts to produce one response bit per challenge. Assembles NBITS response bits into a word handed off with a valid/ack handshake. Sits between the external controller pins and the oscillator banks, replacing free-running ripple counting with a clk-domain measurement.

## Interface
- WINDOW, 64: clk cycles per counting window (≥2).
- SETTLE, 4: clk cycles oscillators run before counting starts (≥1).
- CNT_W, 8: width of each edge counter.
- NBITS, 8: response bits per run (1..32).

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high (despite the name); clears all state.
- start  in  1  request a run; sampled only in IDLE.
- seed  in  5  first challenge of the run.
- ro_a  in  1  selected oscillator, bank A; asynchronous to clk.
- ro_b  in  1  selected oscillator, bank B; asynchronous to clk.
- resp_ack  in  1  consumer accepts response; sampled only in DONE.
- sel  out  5  challenge driven to both oscillator muxes.
- osc_ena  out  1  oscillator enable.
- busy  out  1  high in every state except IDLE.
- response  out  NBITS  assembled response word.
- resp_valid  out  1  response complete and stable.
- ties  out  4  saturating count of equal-count comparisons in the last run.

## Operation
- Reset values: sel=0, osc_ena=0, busy=0, response=0, resp_valid=0, ties=0, counters=0, state IDLE.
- ro_a/ro_b each pass through a 2-flop synchronizer plus a third history flop. A rising edge is counted when sync2=1 and hist=0. Counting is valid only for oscillator frequency < clk/2.
- Edge counters saturate at 2^CNT_W−1. They do not wrap.
- States:
  - IDLE: osc_ena=0. On start=1, load sel=seed, clear response, ties, bit index and counters → SETTLE.
  - SETTLE: osc_ena=1. Counters held at 0. After SETTLE cycles → COUNT.
  - COUNT: osc_ena=1. Counters increment on detected edges. After WINDOW cycles → COMPARE.
  - COMPARE (1 cycle): osc_ena=0.
    - bit = (cnt_a > cnt_b); shift response = {response[NBITS-2:0], bit}.
    - If cnt_a == cnt_b, bit=0 and ties increments (saturating at 15).
    - Clear counters.
    - If bit index = NBITS−1 → DONE. Otherwise increment bit index, sel = sel+1 (mod 32, 31 wraps to 0) → SETTLE.
  - DONE: resp_valid=1, osc_ena=0. On resp_ack=1 → IDLE.
- The first challenge's bit ends in response[NBITS−1]; the last challenge's bit is in response[0].
- response, ties and sel hold their values through DONE and IDLE until the next accepted start.
- start while busy is ignored. start and resp_ack asserted together in DONE: ack is honoured, start is ignored and must be re-asserted in IDLE.
- rst_n mid-run aborts immediately to reset values. No partial response is presented.

## Timing
- All outputs are registered.
- start sampled at edge k: busy=1, osc_ena=1, sel=seed visible after edge k.
- Per-bit period: SETTLE+WINDOW+1 cycles (69 with defaults).
- resp_valid rises NBITS·(SETTLE+WINDOW+1) cycles after the start edge (552 with defaults).
- resp_valid falls, and busy falls, on the edge after resp_ack is sampled in DONE.
- sel changes only on the COMPARE→SETTLE edge. The SETTLE cycles absorb mux and oscillator start-up.
- Synchronizer latency (2 cycles) means up to 2 edges near a window boundary shift into or out of the window. Both counters see identical latency.

## Test plan
- Reset: assert rst_n mid-COUNT → on the same cycle, osc_ena=0, busy=0, resp_valid=0, response=0. After release, state is IDLE.
- Basic run: seed=0, ro_a period 4 clk, ro_b period 6 clk, start pulse → resp_valid at start+552, response=8'hFF, ties=0, final sel=7.
- Reversed and ties:
  - ro_a period 6, ro_b period 4 → response=8'h00, ties=0.
  - Identical ro_a/ro_b → response=8'h00, ties=8.
- Mixed and wrap: seed=30; ro_a faster than ro_b only while sel is even → observe sel sequence 30,31,0,1,…,5 and response=8'b10101010.
- Handshake: hold resp_ack low 20 cycles → resp_valid and response stable. start pulsed during the run is ignored. Assert start and resp_ack together in DONE → returns to IDLE, no new run. A later start begins a new run.
- Saturation: CNT_W=4, ro_a period 2 clk (≥16 edges per window), ro_b period 8 → cnt_a stops at 15, bit=1.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF initiator: steps 5-bit challenges, counts the two selected
// oscillators over a clk-referenced window and packs one comparison bit per challenge.
module puf_challenge_sequencer #(
   parameter int WINDOW = 64,
   parameter int SETTLE = 4,
   parameter int CNT_W  = 8,
   parameter int NBITS  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       seed,
   input  logic             ro_a,
   input  logic             ro_b,
   input  logic             resp_ack,
   output logic [4:0]       sel,
   output logic             osc_ena,
   output logic             busy,
   output logic [NBITS-1:0] response,
   output logic             resp_valid,
   output logic [3:0]       ties
);

   localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_COUNT, S_COMPARE, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr;
   logic [IDX_W-1:0]   bit_idx;
   logic [CNT_W-1:0]   cnt_a, cnt_b;
   logic               ro_a_p0, ro_a_p1, ro_a_p2;
   logic               ro_b_p0, ro_b_p1, ro_b_p2;
   logic               edge_a, edge_b;
   logic               cmp_bit, cmp_tie, last_bit;
   logic               settle_end, window_end;
   logic               osc_ena_d, busy_d, resp_valid_d;

   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != '1)) return v + CNT_W'(1);
      return v;
   endfunction

   function automatic logic [3:0] sat_ties(input logic [3:0] v, input logic inc);
      if (inc && (v != 4'hF)) return v + 4'd1;
      return v;
   endfunction

   assign edge_a     = ro_a_p1 & ~ro_a_p2;
   assign edge_b     = ro_b_p1 & ~ro_b_p2;
   assign cmp_bit    = (cnt_a > cnt_b);
   assign cmp_tie    = (cnt_a == cnt_b);
   assign last_bit   = (bit_idx == IDX_W'(NBITS - 1));
   assign settle_end = (tmr == TMR_W'(SETTLE - 1));
   assign window_end = (tmr == TMR_W'(WINDOW - 1));

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start)      state_d = S_SETTLE;
         S_SETTLE:  if (settle_end) state_d = S_COUNT;
         S_COUNT:   if (window_end) state_d = S_COMPARE;
         S_COMPARE: state_d = last_bit ? S_DONE : S_SETTLE;
         S_DONE:    if (resp_ack)   state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered with it.
   always_comb begin
      osc_ena_d    = (state_d == S_SETTLE) || (state_d == S_COUNT);
      busy_d       = (state_d != S_IDLE);
      resp_valid_d = (state_d == S_DONE);
   end

   // Stage p0/p1 synchronise the asynchronous oscillators; p2 is the edge-history flop.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         ro_a_p0 <= 1'b0; ro_a_p1 <= 1'b0; ro_a_p2 <= 1'b0;
         ro_b_p0 <= 1'b0; ro_b_p1 <= 1'b0; ro_b_p2 <= 1'b0;
      end else begin
         ro_a_p0 <= ro_a; ro_a_p1 <= ro_a_p0; ro_a_p2 <= ro_a_p1;
         ro_b_p0 <= ro_b; ro_b_p1 <= ro_b_p0; ro_b_p2 <= ro_b_p1;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         osc_ena    <= 1'b0;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         sel        <= '0;
         response   <= '0;
         ties       <= '0;
         bit_idx    <= '0;
         tmr        <= '0;
         cnt_a      <= '0;
         cnt_b      <= '0;
      end else begin
         osc_ena    <= osc_ena_d;
         busy       <= busy_d;
         resp_valid <= resp_valid_d;

         if (((state_q == S_SETTLE) || (state_q == S_COUNT)) && (state_d == state_q))
            tmr <= tmr + TMR_W'(1);
         else
            tmr <= '0;

         if (state_q == S_COUNT) begin
            cnt_a <= sat_cnt(cnt_a, edge_a);
            cnt_b <= sat_cnt(cnt_b, edge_b);
         end else begin
            cnt_a <= '0;
            cnt_b <= '0;
         end

         if ((state_q == S_IDLE) && start) begin
            sel      <= seed;
            response <= '0;
            ties     <= '0;
            bit_idx  <= '0;
         end else if (state_q == S_COMPARE) begin
            response <= (response << 1) | NBITS'(cmp_bit);
            ties     <= sat_ties(ties, cmp_tie);
            if (!last_bit) begin
               bit_idx <= bit_idx + IDX_W'(1);
               sel     <= sel + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: behavioural oscillators, table-driven runs,
// scoreboard of expected words, handshake, reset and counter-saturation sequences.
module tb_puf_challenge_sequencer;

   localparam int NB  = 8;
   localparam int SET = 4;
   localparam int WIN = 64;
   localparam int PER = SET + WIN + 1;
   localparam int LAT = NB * PER;

   localparam int M_FAST_A = 0;
   localparam int M_FAST_B = 1;
   localparam int M_EQUAL  = 2;
   localparam int M_MIXED  = 3;

   typedef struct {
      logic [4:0] seed;
      int         mode;
      logic [7:0] exp_resp;
      logic [3:0] exp_ties;
      logic [4:0] exp_sel;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n, start, ro_a, ro_b, resp_ack;
   logic [4:0] seed, sel;
   logic osc_ena, busy, resp_valid;
   logic [7:0] response;
   logic [3:0] ties;

   logic start2, ro_a2, ro_b2, ack2;
   logic [4:0] seed2, sel2;
   logic osc2, busy2, valid2;
   logic [1:0] resp2;
   logic [3:0] ties2;

   int checks = 0;
   int errors = 0;
   int mode   = M_FAST_A;
   vec_t vecs[4];
   vec_t sb[$];

   always #5 clk = ~clk;

   puf_challenge_sequencer #(.WINDOW(WIN), .SETTLE(SET), .CNT_W(8), .NBITS(NB)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .ro_a(ro_a), .ro_b(ro_b),
      .resp_ack(resp_ack), .sel(sel), .osc_ena(osc_ena), .busy(busy), .response(response),
      .resp_valid(resp_valid), .ties(ties));

   puf_challenge_sequencer #(.WINDOW(WIN), .SETTLE(SET), .CNT_W(4), .NBITS(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .ro_a(ro_a2), .ro_b(ro_b2),
      .resp_ack(ack2), .sel(sel2), .osc_ena(osc2), .busy(busy2), .response(resp2),
      .resp_valid(valid2), .ties(ties2));

   function automatic logic sq(input int ph, input int per);
      return (ph % per) < (per / 2);
   endfunction

   // Oscillator models: periods in clk cycles, changing on the falling edge.
   initial begin
      int phase;
      phase = 0;
      ro_a = 1'b0; ro_b = 1'b0; ro_a2 = 1'b0; ro_b2 = 1'b0;
      forever begin
         @(negedge clk);
         phase++;
         case (mode)
            M_FAST_A: begin ro_a = sq(phase, 4); ro_b = sq(phase, 6); end
            M_FAST_B: begin ro_a = sq(phase, 6); ro_b = sq(phase, 4); end
            M_EQUAL:  begin ro_a = sq(phase, 4); ro_b = sq(phase, 4); end
            default: begin
               ro_a = sq(phase, sel[0] ? 6 : 4);
               ro_b = sq(phase, sel[0] ? 4 : 6);
            end
         endcase
         ro_a2 = sq(phase, 2);
         ro_b2 = sq(phase, 8);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input bit pulse_start);
      int lat;
      logic [4:0] es;
      vec_t e;
      mode = v.mode;
      sb.push_back(v);
      @(negedge clk); seed = v.seed; start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("busy_after_start", busy, 1);
      check("osc_ena_after_start", osc_ena, 1);
      lat = 0;
      while (!resp_valid && lat < LAT + 50) begin
         if ((lat % PER == 0) && (lat / PER < NB)) begin
            es = v.seed + 5'(lat / PER);
            check("sel_sequence", sel, es);
         end
         if (lat == PER - 1) check("osc_ena_compare_low", osc_ena, 0);
         if (lat == PER)     check("osc_ena_resettle", osc_ena, 1);
         if (pulse_start && lat == 100) begin
            start = 1'b1; seed = 5'd17;
         end else begin
            start = 1'b0;
         end
         @(negedge clk); lat++;
      end
      check("resp_valid_latency", lat, LAT);
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("response", response, e.exp_resp);
         check("ties", ties, e.exp_ties);
         check("final_sel", sel, e.exp_sel);
      end
   endtask

   task automatic handshake(input logic [7:0] exp_resp, input logic [4:0] exp_sel, input bit with_start);
      bit stable;
      stable = 1'b1;
      resp_ack = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || response !== exp_resp || busy !== 1'b1) stable = 1'b0;
      end
      check("done_hold_stable", stable, 1);
      resp_ack = 1'b1; start = with_start;
      @(negedge clk);
      resp_ack = 1'b0; start = 1'b0;
      check("resp_valid_fall", resp_valid, 0);
      check("busy_fall", busy, 0);
      repeat (3) @(negedge clk);
      check("idle_no_new_run", busy, 0);
      check("idle_response_held", response, exp_resp);
      check("idle_sel_held", sel, exp_sel);
   endtask

   initial begin
      int lat;
      vecs[0] = '{seed: 5'd0,  mode: M_FAST_A, exp_resp: 8'hFF, exp_ties: 4'd0, exp_sel: 5'd7};
      vecs[1] = '{seed: 5'd0,  mode: M_FAST_B, exp_resp: 8'h00, exp_ties: 4'd0, exp_sel: 5'd7};
      vecs[2] = '{seed: 5'd9,  mode: M_EQUAL,  exp_resp: 8'h00, exp_ties: 4'd8, exp_sel: 5'd16};
      vecs[3] = '{seed: 5'd30, mode: M_MIXED,  exp_resp: 8'hAA, exp_ties: 4'd0, exp_sel: 5'd5};

      rst_n = 1'b1; start = 1'b0; seed = '0; resp_ack = 1'b0;
      start2 = 1'b0; seed2 = '0; ack2 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sel", sel, 0);
      check("rst_osc_ena", osc_ena, 0);
      check("rst_busy", busy, 0);
      check("rst_response", response, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_ties", ties, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i], i == 0);
         handshake(vecs[i].exp_resp, vecs[i].exp_sel, i == 1);
      end

      // Abort mid-COUNT: outputs must drop while reset is still asserted.
      mode = M_FAST_A;
      @(negedge clk); seed = 5'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (30) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrun_rst_osc_ena", osc_ena, 0);
      check("midrun_rst_busy", busy, 0);
      check("midrun_rst_resp_valid", resp_valid, 0);
      check("midrun_rst_response", response, 0);
      check("midrun_rst_sel", sel, 0);
      @(negedge clk); rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle", busy, 0);

      // Counter saturation on the narrow-counter instance.
      @(negedge clk); seed2 = 5'd0; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      lat = 0;
      while (!valid2 && lat < 2 * PER + 50) begin
         if (lat == SET + WIN) check("sat_cnt_a", u_sat.cnt_a, 15);
         @(negedge clk); lat++;
      end
      check("sat_latency", lat, 2 * PER);
      check("sat_response", resp2, 2'b11);
      check("sat_ties", ties2, 0);
      @(negedge clk); ack2 = 1'b1;
      @(negedge clk); ack2 = 1'b0;
      check("sat_idle", busy2, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
